// File: rtl/fano_ber_ctrl.sv
// BER measurement controller for a Fano decoder: waits for decoder sync, locks a
// PRBS15 checker onto the decoded stream, then counts bit errors over a window.
module fano_ber_ctrl #(
    parameter int unsigned PRS_W     = 15,
    parameter int unsigned CHECK_LEN = 64,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_window,
    input  logic [23:0] i_sync_timeout,
    input  logic [7:0]  i_lock_thresh,
    input  logic        i_is_sync,
    input  logic        i_dec_vld,
    input  logic        i_dec_sym,
    output logic        o_err_en,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_state,
    output logic [31:0] o_bit_cnt,
    output logic [31:0] o_err_cnt,
    output logic        o_timeout,
    output logic        o_lock_fail,
    output logic        o_sync_lost
);
    localparam int unsigned LW = $clog2(PRS_W + 1);
    localparam int unsigned CW = $clog2(CHECK_LEN + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        LOAD      = 3'd2,
        CHECK     = 3'd3,
        MEASURE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        win_q, win_d;
    logic [23:0]        tmo_q, tmo_d;
    logic [7:0]         thr_q, thr_d;
    logic [23:0]        cyc_q, cyc_d;
    logic [PRS_W-1:0]   lfsr_q, lfsr_d;
    logic [LW-1:0]      ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]      chk_cnt_q, chk_cnt_d;
    logic [CW-1:0]      mis_q, mis_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [31:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]        err_cnt_q, err_cnt_d;
    logic               timeout_q, timeout_d;
    logic               lock_fail_q, lock_fail_d;
    logic               sync_lost_q, sync_lost_d;
    logic               done_q, done_d;

    logic               pred;
    logic               mis;
    logic [CW-1:0]      mis_tot;

    // Generator x^15+x^14+1 with the newest bit at lfsr[0].
    assign pred    = lfsr_q[PRS_W-1] ^ lfsr_q[PRS_W-2];
    assign mis     = pred ^ i_dec_sym;
    assign mis_tot = mis_q + CW'(mis);

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            win_q       <= '0;
            tmo_q       <= '0;
            thr_q       <= '0;
            cyc_q       <= '0;
            lfsr_q      <= '0;
            ld_cnt_q    <= '0;
            chk_cnt_q   <= '0;
            mis_q       <= '0;
            retry_q     <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            lock_fail_q <= 1'b0;
            sync_lost_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            tmo_q       <= tmo_d;
            thr_q       <= thr_d;
            cyc_q       <= cyc_d;
            lfsr_q      <= lfsr_d;
            ld_cnt_q    <= ld_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            mis_q       <= mis_d;
            retry_q     <= retry_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            timeout_q   <= timeout_d;
            lock_fail_q <= lock_fail_d;
            sync_lost_q <= sync_lost_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        tmo_d       = tmo_q;
        thr_d       = thr_q;
        cyc_d       = cyc_q;
        lfsr_d      = lfsr_q;
        ld_cnt_d    = ld_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        mis_d       = mis_q;
        retry_d     = retry_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        timeout_d   = timeout_q;
        lock_fail_d = lock_fail_q;
        sync_lost_d = sync_lost_q;
        done_d      = 1'b0;

        if (i_abort) begin
            state_d = IDLE;
        end else if ((state_q == LOAD || state_q == CHECK || state_q == MEASURE) && !i_is_sync) begin
            sync_lost_d = 1'b1;
            state_d     = DONE;
            done_d      = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        state_d     = WAIT_SYNC;
                        win_d       = i_window;
                        tmo_d       = i_sync_timeout;
                        thr_d       = i_lock_thresh;
                        cyc_d       = '0;
                        ld_cnt_d    = '0;
                        chk_cnt_d   = '0;
                        mis_d       = '0;
                        retry_d     = '0;
                        bit_cnt_d   = '0;
                        err_cnt_d   = '0;
                        timeout_d   = 1'b0;
                        lock_fail_d = 1'b0;
                        sync_lost_d = 1'b0;
                    end
                end
                WAIT_SYNC: begin
                    if (i_is_sync) begin
                        state_d  = LOAD;
                        ld_cnt_d = '0;
                    end else if (cyc_q == tmo_q) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                        done_d    = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 24'd1;
                    end
                end
                LOAD: begin
                    if (i_dec_vld) begin
                        lfsr_d = {lfsr_q[PRS_W-2:0], i_dec_sym};
                        if (ld_cnt_q == LW'(PRS_W - 1)) begin
                            state_d   = CHECK;
                            chk_cnt_d = '0;
                            mis_d     = '0;
                        end else begin
                            ld_cnt_d = ld_cnt_q + LW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (i_dec_vld) begin
                        lfsr_d = {lfsr_q[PRS_W-2:0], pred};
                        if (chk_cnt_q == CW'(CHECK_LEN - 1)) begin
                            if ({{(32-CW){1'b0}}, mis_tot} <= {24'd0, thr_q}) begin
                                state_d = MEASURE;
                            end else if (retry_q == RW'(MAX_RETRY - 1)) begin
                                retry_d     = retry_q + RW'(1);
                                lock_fail_d = 1'b1;
                                state_d     = DONE;
                                done_d      = 1'b1;
                            end else begin
                                retry_d  = retry_q + RW'(1);
                                ld_cnt_d = '0;
                                state_d  = LOAD;
                            end
                        end else begin
                            chk_cnt_d = chk_cnt_q + CW'(1);
                            mis_d     = mis_tot;
                        end
                    end
                end
                MEASURE: begin
                    // Window check first so a zero window finishes without counting.
                    if (bit_cnt_q == win_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (i_dec_vld) begin
                        lfsr_d    = {lfsr_q[PRS_W-2:0], pred};
                        bit_cnt_d = bit_cnt_q + 32'd1;
                        if (mis && err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign o_state     = state_q;
    assign o_busy      = (state_q == WAIT_SYNC) || (state_q == LOAD) ||
                         (state_q == CHECK) || (state_q == MEASURE);
    assign o_err_en    = (state_q == MEASURE);
    assign o_done      = done_q;
    assign o_bit_cnt   = bit_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_timeout   = timeout_q;
    assign o_lock_fail = lock_fail_q;
    assign o_sync_lost = sync_lost_q;

endmodule

// File: tb/tb_fano_ber_ctrl.sv
// Self-checking bench for fano_ber_ctrl: table vectors, directed corner cases and
// randomized streams checked against a bit-list reference model.
module tb_fano_ber_ctrl;
    localparam int unsigned PRS_W     = 15;
    localparam int unsigned CHECK_LEN = 64;
    localparam int unsigned MAX_RETRY = 4;
    localparam int unsigned PRE       = PRS_W + CHECK_LEN;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        i_start, i_abort, i_is_sync, i_dec_vld, i_dec_sym;
    logic [31:0] i_window;
    logic [23:0] i_sync_timeout;
    logic [7:0]  i_lock_thresh;
    logic        o_err_en, o_busy, o_done, o_timeout, o_lock_fail, o_sync_lost;
    logic [2:0]  o_state;
    logic [31:0] o_bit_cnt, o_err_cnt;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int en_cycles = 0;
    int phase_bad = 0;
    bit rx[];

    typedef struct {
        int unsigned win;
        int unsigned thr;
        int unsigned period;
        int unsigned chk_err;
        int unsigned exp_bits;
        int unsigned exp_errs;
    } vec_t;
    vec_t vecs[6];

    fano_ber_ctrl #(.PRS_W(PRS_W), .CHECK_LEN(CHECK_LEN), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .nRESET(nRESET), .i_start(i_start), .i_abort(i_abort),
        .i_window(i_window), .i_sync_timeout(i_sync_timeout), .i_lock_thresh(i_lock_thresh),
        .i_is_sync(i_is_sync), .i_dec_vld(i_dec_vld), .i_dec_sym(i_dec_sym),
        .o_err_en(o_err_en), .o_busy(o_busy), .o_done(o_done), .o_state(o_state),
        .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_timeout(o_timeout),
        .o_lock_fail(o_lock_fail), .o_sync_lost(o_sync_lost)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_done) done_seen++;
        if (o_err_en) en_cycles++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // PRBS15 sequence from the recurrence b[n] = b[n-15] ^ b[n-14].
    task automatic build_stream(input logic [14:0] seed, input int unsigned len);
        logic [14:0] s;
        s = (seed == 15'd0) ? 15'd1 : seed;
        rx = new[len];
        for (int i = 0; i < 15; i++) rx[i] = s[i];
        for (int i = 15; i < int'(len); i++) rx[i] = rx[i-15] ^ rx[i-14];
    endtask

    function automatic void ref_model(input int unsigned win, input int unsigned thr,
                                      output int unsigned used, output int unsigned bits,
                                      output int unsigned errs, output bit lfail);
        int unsigned pos;
        int unsigned mism;
        bit seq[$];
        bit p;
        pos = 0; bits = 0; errs = 0; lfail = 1'b1;
        for (int t = 0; t < int'(MAX_RETRY); t++) begin
            seq.delete();
            for (int i = 0; i < int'(PRS_W); i++) seq.push_back(rx[pos + i]);
            pos += PRS_W;
            mism = 0;
            for (int i = 0; i < int'(CHECK_LEN); i++) begin
                p = seq[seq.size()-15] ^ seq[seq.size()-14];
                seq.push_back(p);
                if (p != rx[pos]) mism++;
                pos++;
            end
            if (mism <= thr) begin
                lfail = 1'b0;
                break;
            end
        end
        if (!lfail) begin
            for (int i = 0; i < int'(win); i++) begin
                p = seq[seq.size()-15] ^ seq[seq.size()-14];
                seq.push_back(p);
                if (p != rx[pos]) errs++;
                pos++;
                bits++;
            end
        end
        used = pos;
    endfunction

    task automatic start_run(input logic [31:0] win, input logic [7:0] thr,
                             input logic [23:0] tmo, input logic sync);
        i_window = win; i_lock_thresh = thr; i_sync_timeout = tmo; i_is_sync = sync;
        i_start = 1'b1;
        done_seen = 0; en_cycles = 0;
        tick();
        i_start = 1'b0;
        i_window = $urandom; i_lock_thresh = 8'($urandom); i_sync_timeout = 24'($urandom);
        check("start_clear", {o_state, o_timeout, o_lock_fail, o_sync_lost,
                              1'b0 | (|o_bit_cnt), 1'b0 | (|o_err_cnt)}, {3'd1, 5'd0});
    endtask

    // A strobe during WAIT_SYNC must be ignored.
    task automatic enter_load();
        i_dec_vld = 1'b1; i_dec_sym = 1'($urandom);
        tick();
        i_dec_vld = 1'b0;
        check("load_entry", o_state, 3'd2);
    endtask

    task automatic send_bits(input int unsigned first, input int unsigned n, input bit phase_chk);
        logic [2:0] exp_st;
        for (int unsigned k = first; k < first + n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                i_dec_vld = 1'b0; i_dec_sym = 1'($urandom);
                tick();
            end
            if (phase_chk) begin
                exp_st = (k < PRS_W) ? 3'd2 : (k < PRE) ? 3'd3 : 3'd4;
                if (o_state != exp_st || o_err_en != (k >= PRE)) phase_bad++;
            end
            i_dec_vld = 1'b1; i_dec_sym = rx[k];
            tick();
            i_dec_vld = 1'b0;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (o_state != 3'd5 && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic model_run(input string tag, input int unsigned win, input int unsigned thr);
        int unsigned used, bits, errs;
        bit lf;
        int lat;
        ref_model(win, thr, used, bits, errs, lf);
        start_run(win, 8'(thr), 24'd100, 1'b1);
        enter_load();
        send_bits(0, used, 1'b0);
        wait_done(lat);
        check({tag, "_state"}, o_state, 3'd5);
        check({tag, "_bits"}, o_bit_cnt, bits);
        check({tag, "_errs"}, o_err_cnt, errs);
        check({tag, "_flags"}, {o_timeout, o_lock_fail, o_sync_lost}, {1'b0, lf, 1'b0});
        check({tag, "_done_cnt"}, done_seen, 1);
        if (lf) check({tag, "_err_en_never"}, en_cycles, 0);
    endtask

    initial begin
        int lat;
        int n;
        vecs[0] = '{1000, 2, 0,   0, 1000, 0};
        vecs[1] = '{1000, 2, 100, 0, 1000, 10};
        vecs[2] = '{0,    2, 0,   0, 0,    0};
        vecs[3] = '{37,   0, 5,   0, 37,   7};
        vecs[4] = '{1,    0, 1,   0, 1,    1};
        vecs[5] = '{64,   2, 8,   2, 64,   8};

        nRESET = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_is_sync = 1'b0;
        i_dec_vld = 1'b0; i_dec_sym = 1'b0;
        i_window = '0; i_sync_timeout = '0; i_lock_thresh = '0;
        repeat (3) tick();
        check("rst_outputs", {o_state, o_busy, o_done, o_err_en, o_timeout, o_lock_fail, o_sync_lost}, '0);
        check("rst_counts", {o_bit_cnt, o_err_cnt}, '0);
        nRESET = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            build_stream(15'h5a3c + 15'(v), PRE + vecs[v].win + 16);
            for (int unsigned j = 0; j < vecs[v].chk_err; j++) rx[PRS_W + 10*j] ^= 1'b1;
            if (vecs[v].period != 0)
                for (int unsigned i = 0; i < vecs[v].win; i++)
                    if (i % vecs[v].period == vecs[v].period - 1) rx[PRE + i] ^= 1'b1;
            start_run(vecs[v].win, 8'(vecs[v].thr), 24'd100, 1'b1);
            enter_load();
            phase_bad = 0;
            send_bits(0, PRE + vecs[v].win, 1'b1);
            wait_done(lat);
            check($sformatf("vec%0d_bits", v), o_bit_cnt, vecs[v].exp_bits);
            check($sformatf("vec%0d_errs", v), o_err_cnt, vecs[v].exp_errs);
            check($sformatf("vec%0d_flags", v), {o_timeout, o_lock_fail, o_sync_lost}, 3'd0);
            check($sformatf("vec%0d_done_latency", v), lat, 1);
            check($sformatf("vec%0d_done_cnt", v), done_seen, 1);
            check($sformatf("vec%0d_phase", v), phase_bad, 0);
            check($sformatf("vec%0d_idle_outs", v), {o_state, o_busy, o_err_en}, {3'd5, 2'b00});
            repeat (2) tick();
            check($sformatf("vec%0d_hold", v), {o_done, o_bit_cnt, o_err_cnt},
                  {1'b0, vecs[v].exp_bits, vecs[v].exp_errs});
        end

        // Sync lost after 300 measured bits.
        build_stream(15'h1234, PRE + 320);
        start_run(32'd1000, 8'd2, 24'd100, 1'b1);
        enter_load();
        phase_bad = 0;
        send_bits(0, PRE + 300, 1'b1);
        i_is_sync = 1'b0;
        tick();
        check("synclost_state", o_state, 3'd5);
        check("synclost_flags", {o_timeout, o_lock_fail, o_sync_lost}, 3'b001);
        check("synclost_bits", o_bit_cnt, 300);
        check("synclost_done", done_seen, 1);
        check("synclost_phase", phase_bad, 0);
        i_is_sync = 1'b1;
        repeat (2) tick();
        check("synclost_hold", {o_done, o_bit_cnt}, {1'b0, 32'd300});

        // Timeout: WAIT_SYNC spends one cycle per count value 0..50, then DONE.
        start_run(32'd10, 8'd0, 24'd50, 1'b0);
        n = 0;
        while (o_state == 3'd1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 51);
        check("timeout_flags", {o_state, o_timeout, o_lock_fail, o_sync_lost}, {3'd5, 3'b100});
        check("timeout_done", done_seen, 1);

        // Sync arriving in the same cycle as the timeout match wins.
        start_run(32'd10, 8'd0, 24'd50, 1'b0);
        repeat (50) tick();
        check("race_still_waiting", o_state, 3'd1);
        i_is_sync = 1'b1;
        tick();
        check("race_sync_wins", {o_state, o_timeout, o_done}, {3'd2, 2'b00});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("race_abort_idle", {o_state, o_busy}, {3'd0, 1'b0});
        check("race_no_done", done_seen, 0);

        // Random bits with zero threshold: four failed checks.
        rx = new[4 * PRE + 10];
        for (int i = 0; i < 4 * int'(PRE) + 10; i++) rx[i] = 1'($urandom);
        model_run("lockfail", 100, 0);
        check("lockfail_flag", o_lock_fail, 1'b1);

        // Two check mismatches against threshold 1: one retry, then lock.
        build_stream(15'h0f0f, 4 * PRE + 100);
        rx[20] ^= 1'b1;
        rx[30] ^= 1'b1;
        model_run("retry", 50, 1);

        for (int r = 0; r < 8; r++) begin
            build_stream(15'($urandom), 4 * PRE + 310);
            for (int i = 0; i < 4 * int'(PRE) + 310; i++)
                if ($urandom_range(0, 47) == 0) rx[i] ^= 1'b1;
            model_run($sformatf("rand%0d", r), $urandom_range(0, 300), $urandom_range(0, 5));
        end

        // Abort together with start mid-MEASURE.
        build_stream(15'h2222, PRE + 40);
        start_run(32'd1000, 8'd2, 24'd100, 1'b1);
        enter_load();
        send_bits(0, PRE + 20, 1'b0);
        i_abort = 1'b1; i_start = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        check("abort_state", {o_state, o_busy, o_err_en}, {3'd0, 2'b00});
        check("abort_counts", o_bit_cnt, 20);
        check("abort_no_done_flags", {done_seen[3:0], o_timeout, o_lock_fail, o_sync_lost}, '0);
        tick();
        check("abort_stays_idle", o_state, 3'd0);

        // Reset mid-run.
        build_stream(15'h3333, PRE + 40);
        start_run(32'd1000, 8'd2, 24'd100, 1'b1);
        enter_load();
        send_bits(0, PRE + 10, 1'b0);
        nRESET = 1'b0;
        tick();
        check("midrst_outputs", {o_state, o_busy, o_done, o_err_en, o_timeout, o_lock_fail,
                                 o_sync_lost, 1'b0 | (|o_bit_cnt), 1'b0 | (|o_err_cnt)}, '0);
        nRESET = 1'b1;
        tick();
        check("midrst_no_done", done_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
